instr_fifo: RTL and testbench
=============================

// Module: instr_fifo
// PURPOSE
//   Instruction buffer between the host write side and the control unit fetch stage.
//   Stores 23-bit zoom instructions {ch[2:0], x[9:0], y[9:0]} in arrival order and
//   delivers one per accepted read. Read data is registered: a read accepted in the
//   FETCH cycle presents the instruction in the following DECODE cycle.
//   Single clock domain. Full, empty and almost_full flags. Sticky overflow and
//   underflow error flags.
// PARAMETERS
//   DATA_W     23  instruction width
//   DEPTH      16  number of entries; must be a power of 2, minimum 2
//   ADDR_W     4   log2(DEPTH)
//   AFULL_LVL  12  almost_full is asserted when count >= AFULL_LVL
// PORTS
//   clock        in   1         system clock; all registers update on its rising edge
//   reset_n      in   1         asynchronous reset, active-low
//   wr_en        in   1         write request (driven by the control unit wr_ins / host)
//   wr_data      in   DATA_W    instruction to write
//   rd_en        in   1         read request; driven by the control unit pc_count
//   rd_data      out  DATA_W    registered read data, feeds the control unit instruction input
//   rd_valid     out  1         one-cycle pulse: rd_data was updated by an accepted read
//   empty        out  1         count == 0
//   full         out  1         count == DEPTH
//   almost_full  out  1         count >= AFULL_LVL
//   count        out  ADDR_W+1  number of stored entries, 0..DEPTH
//   overflow     out  1         sticky: a write was rejected
//   underflow    out  1         sticky: a read was rejected
//   clr_err      in   1         synchronous clear of overflow and underflow
// BEHAVIOUR
// - Reset (reset_n=0, takes effect immediately, without waiting for a clock edge):
//   - wr_ptr, rd_ptr, count, rd_data, rd_valid, overflow, underflow all = 0
//   - empty=1; full=0; almost_full=0
//   - Memory contents are don't-care.
//   - Reset asserted mid-operation discards all stored entries.
// - Read accept = rd_en & !empty.
//   - On accept: rd_data <= mem[rd_ptr]; rd_ptr++; rd_valid=1 in the next cycle.
//   - Latency is 1 cycle from accept to valid rd_data.
// - Write accept = wr_en & (!full | rd_accept).
//   - On accept: mem[wr_ptr] <= wr_data; wr_ptr++.
//   - When full, a simultaneous read frees the slot, so the write is accepted.
// - count update:
//   - +1 on write only, -1 on read only
//   - unchanged on both or on neither
// - Flags empty, full and almost_full are derived from the registered count. They are
//   valid in the same cycle as count.
// - Pointers wrap naturally modulo DEPTH. No sideband wrap bit is needed because count
//   is kept explicitly.
// - Empty with wr_en & rd_en in the same cycle:
//   - The read is rejected and the underflow flag is set.
//   - The write is accepted; count becomes 1.
//   - rd_data holds. No write-through bypass.
// - Rejected read: rd_data holds its previous value; rd_valid=0; underflow <= 1.
// - Rejected write (full & !rd_accept): data is dropped; memory is unchanged; overflow <= 1.
// - clr_err: clears overflow and underflow on the next edge. If a new error occurs in the
//   same cycle as clr_err, the set wins.
// - rd_data is stable while rd_en=0. The control unit samples it in DECODE, and it stays
//   stable through EXECUTE until the next read.
// TESTING
// 1. Reset check: assert reset_n=0 mid-stream with no clock edge.
//    -> All outputs go to reset values immediately; empty=1, count=0.
// 2. Order and latency: write 0x1ABCDE, 0x000001, 0x7FFFFF; then rd_en for 3 cycles.
//    -> rd_data is 0x1ABCDE, 0x000001, 0x7FFFFF on the cycles after each read,
//       rd_valid=1 each time.
// 3. Fill to full: write 16 entries.
//    -> almost_full rises at count=12, full=1 at count=16.
//    A 17th write -> dropped, overflow=1, count stays 16.
//    Then clr_err -> overflow=0.
// 4. Full with simultaneous wr_en and rd_en.
//    -> Both accepted, count stays 16, no overflow.
//    Drain 16 entries -> new entry emerges last.
// 5. Empty with rd_en only -> underflow=1, rd_data unchanged.
//    Empty with wr_en & rd_en -> count=1, underflow=1, next read returns the written word.
// 6. Wrap-around: run 40 write/read pairs at count 0..3.
//    -> Data matches a scoreboard through multiple pointer wraps. No spurious flags.

Source files
------------

// File: rtl/instr_fifo.sv
// Instruction buffer between the host write side and the control unit fetch stage.
// Holds {ch, x, y} zoom instructions in arrival order; read data is registered.
module instr_fifo #(
    parameter int unsigned DATA_W    = 23,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = $clog2(DEPTH),
    parameter int unsigned AFULL_LVL = 12
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_nxt_c;
    logic              rd_accept_c;
    logic              wr_accept_c;
    logic              wr_reject_c;
    logic              rd_reject_c;

    // Accept decisions; a read on a full buffer frees the slot for a same-cycle write.
    always_comb begin
        rd_accept_c = rd_en & ~empty;
        wr_accept_c = wr_en & (~full | rd_accept_c);
        wr_reject_c = wr_en & ~wr_accept_c;
        rd_reject_c = rd_en & empty;
        count_nxt_c = count;
        case ({wr_accept_c, rd_accept_c})
            2'b10:   count_nxt_c = count + CNT_W'(1);
            2'b01:   count_nxt_c = count - CNT_W'(1);
            default: count_nxt_c = count;
        endcase
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (wr_accept_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the flags decoded from the next occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (wr_accept_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_accept_c) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count       <= count_nxt_c;
            empty       <= (count_nxt_c == '0);
            full        <= (count_nxt_c == CNT_W'(DEPTH));
            almost_full <= (count_nxt_c >= CNT_W'(AFULL_LVL));
        end
    end

    // Registered read port; rd_data holds until the next accepted read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept_c;
            if (rd_accept_c) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_reject_c) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_reject_c) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fifo.sv
// Bench for instr_fifo: scoreboard model plus a vector table for the fill sequence.
module tb_instr_fifo;

    localparam int unsigned DATA_W = 23;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AFULL  = 12;

    logic              clock;
    logic              reset_n;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [4:0]        count;
    logic              overflow;
    logic              underflow;
    logic              clr_err;

    instr_fifo dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_err     (clr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [DATA_W-1:0] sb_q[$];
    logic [DATA_W-1:0] m_rd_data;
    logic              m_rd_valid;
    logic              m_ovf;
    logic              m_udf;

    typedef struct {
        logic              wr;
        logic [DATA_W-1:0] data;
        logic              rd;
        logic              clr;
        int                exp_count;
        logic              exp_full;
        logic              exp_afull;
        logic              exp_ovf;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_ovf      = 1'b0;
        m_udf      = 1'b0;
    endtask

    // Drive one cycle, advance the model, then compare everything #1 after the edge.
    task automatic step(input logic wr, input logic [DATA_W-1:0] d, input logic rd,
                        input logic clr);
        logic rd_acc;
        logic wr_acc;
        int   n;
        n      = sb_q.size();
        rd_acc = rd && (n != 0);
        wr_acc = wr && ((n < DEPTH) || rd_acc);
        if (rd_acc) m_rd_data = sb_q.pop_front();
        if (wr_acc) sb_q.push_back(d);
        m_rd_valid = rd_acc;
        if (wr && !wr_acc) m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        if (rd && n == 0)  m_udf = 1'b1;
        else if (clr)      m_udf = 1'b0;

        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        clr_err = clr;
        @(posedge clock);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        n = sb_q.size();
        chk("count",       32'(count),       32'(n));
        chk("empty",       32'(empty),       32'(n == 0));
        chk("full",        32'(full),        32'(n == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(n >= AFULL));
        chk("overflow",    32'(overflow),    32'(m_ovf));
        chk("underflow",   32'(underflow),   32'(m_udf));
        chk("rd_valid",    32'(rd_valid),    32'(m_rd_valid));
        chk("rd_data",     32'(rd_data),     32'(m_rd_data));
    endtask

    task automatic check_reset_outputs();
        chk("rst_count",     32'(count),       32'd0);
        chk("rst_empty",     32'(empty),       32'd1);
        chk("rst_full",      32'(full),        32'd0);
        chk("rst_afull",     32'(almost_full), 32'd0);
        chk("rst_rd_data",   32'(rd_data),     32'd0);
        chk("rst_rd_valid",  32'(rd_valid),    32'd0);
        chk("rst_overflow",  32'(overflow),    32'd0);
        chk("rst_underflow", 32'(underflow),   32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] d;

        // Vector table: 16 fill writes, a rejected 17th write, then clr_err.
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{wr: 1'b1, data: DATA_W'(32'h100 + i), rd: 1'b0, clr: 1'b0,
                        exp_count: i + 1, exp_full: (i == 15), exp_afull: (i >= 11),
                        exp_ovf: 1'b0};
        end
        vecs[16] = '{wr: 1'b1, data: DATA_W'(32'h3FFFFF), rd: 1'b0, clr: 1'b0,
                     exp_count: 16, exp_full: 1'b1, exp_afull: 1'b1, exp_ovf: 1'b1};
        vecs[17] = '{wr: 1'b0, data: '0, rd: 1'b0, clr: 1'b1,
                     exp_count: 16, exp_full: 1'b1, exp_afull: 1'b1, exp_ovf: 1'b0};

        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        model_reset();
        #12;
        check_reset_outputs();
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Order and latency
        step(1'b1, 23'h1ABCDE, 1'b0, 1'b0);
        step(1'b1, 23'h000001, 1'b0, 1'b0);
        step(1'b1, 23'h7FFFFF, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("order0", 32'(rd_data), 32'h1ABCDE);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("order1", 32'(rd_data), 32'h000001);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("order2", 32'(rd_data), 32'h7FFFFF);
        step(1'b0, '0, 1'b0, 1'b0);

        // Fill to full, overflow, clear
        for (int i = 0; i < 18; i++) begin
            step(vecs[i].wr, vecs[i].data, vecs[i].rd, vecs[i].clr);
            chk($sformatf("vec%0d_count", i), 32'(count),       32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_full", i),  32'(full),        32'(vecs[i].exp_full));
            chk($sformatf("vec%0d_afull", i), 32'(almost_full), 32'(vecs[i].exp_afull));
            chk($sformatf("vec%0d_ovf", i),   32'(overflow),    32'(vecs[i].exp_ovf));
        end

        // Full with simultaneous write and read, then drain
        step(1'b1, 23'h155555, 1'b1, 1'b0);
        chk("full_rw_count", 32'(count), 32'd16);
        chk("full_rw_ovf", 32'(overflow), 32'd0);
        chk("full_rw_first", 32'(rd_data), 32'h100);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("drain_last", 32'(rd_data), 32'h155555);
        chk("drain_empty", 32'(empty), 32'd1);

        // Empty corner cases
        step(1'b0, '0, 1'b1, 1'b0);
        chk("udf_set", 32'(underflow), 32'd1);
        chk("udf_hold", 32'(rd_data), 32'h155555);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("udf_clr", 32'(underflow), 32'd0);
        step(1'b1, 23'h0ABCDE, 1'b1, 1'b0);
        chk("empty_rw_count", 32'(count), 32'd1);
        chk("empty_rw_udf", 32'(underflow), 32'd1);
        chk("empty_rw_hold", 32'(rd_data), 32'h155555);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("empty_rw_read", 32'(rd_data), 32'h0ABCDE);
        step(1'b0, '0, 1'b0, 1'b0);

        // Wrap-around: prime 3 entries, 40 simultaneous pairs, drain
        for (int i = 0; i < 3; i++) begin
            d = DATA_W'($urandom);
            step(1'b1, d, 1'b0, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            d = DATA_W'($urandom);
            step(1'b1, d, 1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1);

        // Reset mid-stream, between clock edges
        step(1'b1, 23'h012345, 1'b0, 1'b0);
        step(1'b1, 23'h054321, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 23'h2468AC, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("post_reset_read", 32'(rd_data), 32'h2468AC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
